// File: rtl/rho_rotate_controller.sv
// Control sequencer for the Keccak rho step: reads each lane, rotates the shared
// lane register left by the lane's rho offset (one bit per cycle), writes it back.
module rho_rotate_controller #(
  parameter int LANES  = 25,
  parameter int LANE_W = 64,
  parameter int ADR_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             memRead,
  output logic             memWrite,
  output logic [ADR_W-1:0] adr,
  output logic             regLd,
  output logic             regRotL,
  output logic             done
);

  localparam int ROT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  typedef enum logic [2:0] {
    IDLE, INIT, READ, LOAD, ROTATE, WRITE, DONE
  } state_t;

  state_t           state, stateNext;
  logic [ADR_W-1:0] laneCnt;
  logic [ROT_W-1:0] rotCnt;
  logic [ROT_W-1:0] rotOff;
  logic             lastLane;

  // Rho offsets indexed by x + 5*y; lanes beyond the 5x5 state get no rotation.
  function automatic int rhoRaw(input logic [ADR_W-1:0] idx);
    int r;
    r = 0;
    case (int'(idx))
      0:  r = 0;   1:  r = 1;   2:  r = 62;  3:  r = 28;  4:  r = 27;
      5:  r = 36;  6:  r = 44;  7:  r = 6;   8:  r = 55;  9:  r = 20;
      10: r = 3;   11: r = 10;  12: r = 43;  13: r = 25;  14: r = 39;
      15: r = 41;  16: r = 45;  17: r = 15;  18: r = 21;  19: r = 8;
      20: r = 18;  21: r = 2;   22: r = 61;  23: r = 56;  24: r = 14;
      default: r = 0;
    endcase
    return r;
  endfunction

  assign rotOff   = ROT_W'(rhoRaw(laneCnt) % LANE_W);
  assign lastLane = (laneCnt == ADR_W'(LANES - 1));
  assign adr      = laneCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      laneCnt <= '0;
      rotCnt  <= '0;
    end else begin
      state <= stateNext;
      case (state)
        INIT:    laneCnt <= '0;
        LOAD:    rotCnt  <= rotOff;
        ROTATE:  rotCnt  <= rotCnt - ROT_W'(1);
        WRITE:   if (!lastLane) laneCnt <= laneCnt + ADR_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    ready     = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regLd     = 1'b0;
    regRotL   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) stateNext = INIT;
      end
      INIT: stateNext = READ;
      READ: begin
        memRead   = 1'b1;
        stateNext = LOAD;
      end
      LOAD: begin
        regLd     = 1'b1;
        stateNext = (rotOff == '0) ? WRITE : ROTATE;
      end
      ROTATE: begin
        regRotL = 1'b1;
        if (rotCnt == ROT_W'(1)) stateNext = WRITE;
      end
      WRITE: begin
        memWrite  = 1'b1;
        stateNext = lastLane ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rho_rotate_controller.sv
// Bench for rho_rotate_controller: per-cycle expected-output queues built from the
// rho table, plus a lane-memory/register model checked against Keccak rho.
module tb_rho_rotate_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start64, start32;
  logic       ready64, memRead64, memWrite64, regLd64, regRotL64, done64;
  logic [4:0] adr64;
  logic       ready32, memRead32, memWrite32, regLd32, regRotL32, done32;
  logic [4:0] adr32;

  rho_rotate_controller #(.LANES(25), .LANE_W(64), .ADR_W(5)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .ready(ready64), .memRead(memRead64),
    .memWrite(memWrite64), .adr(adr64), .regLd(regLd64), .regRotL(regRotL64), .done(done64)
  );

  rho_rotate_controller #(.LANES(25), .LANE_W(32), .ADR_W(5)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ready(ready32), .memRead(memRead32),
    .memWrite(memWrite32), .adr(adr32), .regLd(regLd32), .regRotL(regRotL32), .done(done32)
  );

  typedef logic [10:0] vec_t;  // {ready, memRead, memWrite, regLd, regRotL, done, adr}

  int rhoTab[25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  int   passed = 0, total = 0;
  vec_t q64[$], q32[$], tmpQ[$];
  vec_t e64, e32;
  int   tail64 = 0, tail32 = 0;
  bit   chkEn = 1'b0;
  int   cyc = 0;
  int   doneCyc64 = -1, doneCyc32 = -1, startCyc64 = 0, startCyc32 = 0;
  int   rc64[32], rc32[32];
  bit   loadSeed = 1'b0;

  logic [63:0] seed64[25];
  logic [31:0] seed32[25];
  logic [63:0] mem64[32];
  logic [31:0] mem32[32];
  logic [63:0] rd64, reg64;
  logic [31:0] rd32, reg32;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(bit r, bit rd, bit wr, bit ld, bit rot, bit dn, int a);
    return {r, rd, wr, ld, rot, dn, a[4:0]};
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r, input int w);
    int s;
    s = r % w;
    if (s == 0) return x;
    if (w == 64) return (x << s) | (x >> (64 - s));
    return ((x << s) | (x >> (32 - s))) & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // One run as seen cycle by cycle: the idle cycle that samples start, Init,
  // then Read / Load / offset rotates / Write per lane, then Done.
  task automatic buildRun(input int w, input int tail);
    tmpQ.delete();
    tmpQ.push_back(mk(1, 0, 0, 0, 0, 0, tail));
    tmpQ.push_back(mk(0, 0, 0, 0, 0, 0, tail));
    for (int i = 0; i < 25; i++) begin
      tmpQ.push_back(mk(0, 1, 0, 0, 0, 0, i));
      tmpQ.push_back(mk(0, 0, 0, 1, 0, 0, i));
      for (int k = 0; k < rhoTab[i] % w; k++) tmpQ.push_back(mk(0, 0, 0, 0, 1, 0, i));
      tmpQ.push_back(mk(0, 0, 1, 0, 0, 0, i));
    end
    tmpQ.push_back(mk(0, 0, 0, 0, 0, 1, 24));
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      e64 = (q64.size() > 0) ? q64.pop_front() : mk(1, 0, 0, 0, 0, 0, tail64);
      e32 = (q32.size() > 0) ? q32.pop_front() : mk(1, 0, 0, 0, 0, 0, tail32);
      check("dut64 outputs", {ready64, memRead64, memWrite64, regLd64, regRotL64, done64, adr64}, e64);
      check("dut32 outputs", {ready32, memRead32, memWrite32, regLd32, regRotL32, done32, adr32}, e32);
      if (regRotL64 === 1'b1) rc64[adr64]++;
      if (regRotL32 === 1'b1) rc32[adr32]++;
      if (done64 === 1'b1) doneCyc64 = cyc;
      if (done32 === 1'b1) doneCyc32 = cyc;
    end
    cyc++;
  end

  // Lane datapath beside the controller: synchronous-read memory and lane register.
  always @(posedge clk) begin
    if (loadSeed) begin
      for (int i = 0; i < 25; i++) begin
        mem64[i] <= seed64[i];
        mem32[i] <= seed32[i];
      end
    end else begin
      if (memRead64 === 1'b1) rd64 <= mem64[adr64];
      if (regLd64 === 1'b1) reg64 <= rd64;
      else if (regRotL64 === 1'b1) reg64 <= {reg64[62:0], reg64[63]};
      if (memWrite64 === 1'b1) mem64[adr64] <= reg64;
      if (memRead32 === 1'b1) rd32 <= mem32[adr32];
      if (regLd32 === 1'b1) reg32 <= rd32;
      else if (regRotL32 === 1'b1) reg32 <= {reg32[30:0], reg32[31]};
      if (memWrite32 === 1'b1) mem32[adr32] <= reg32;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic seedMem();
    for (int i = 0; i < 25; i++) begin
      seed64[i] = {$urandom, $urandom};
      seed32[i] = $urandom;
    end
    loadSeed = 1'b1;
    tick();
    loadSeed = 1'b0;
  endtask

  task automatic launch64(input int runs);
    for (int r = 0; r < runs; r++) begin
      buildRun(64, tail64);
      check("model run length 64", tmpQ.size(), 758);
      foreach (tmpQ[k]) q64.push_back(tmpQ[k]);
      tail64 = 24;
    end
    for (int a = 0; a < 32; a++) rc64[a] = 0;
    doneCyc64  = -1;
    startCyc64 = cyc;
    start64    = 1'b1;
  endtask

  task automatic launch32();
    buildRun(32, tail32);
    check("model run length 32", tmpQ.size(), 438);
    foreach (tmpQ[k]) q32.push_back(tmpQ[k]);
    tail32 = 24;
    for (int a = 0; a < 32; a++) rc32[a] = 0;
    doneCyc32  = -1;
    startCyc32 = cyc;
    start32    = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((q64.size() > 0 || q32.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("expected trace consumed within budget", q64.size() + q32.size(), 0);
    tick();
    tick();
  endtask

  task automatic checkMem64(input int upTo, input int times);
    logic [63:0] e;
    for (int i = 0; i < 25; i++) begin
      e = seed64[i];
      if (i < upTo) for (int t = 0; t < times; t++) e = rotl(e, rhoTab[i], 64);
      check($sformatf("mem64 lane %0d", i), mem64[i], e);
    end
  endtask

  task automatic checkMem32();
    for (int i = 0; i < 25; i++)
      check($sformatf("mem32 lane %0d", i), {32'h0, mem32[i]}, rotl({32'h0, seed32[i]}, rhoTab[i], 32));
  endtask

  initial begin
    int n;
    rst = 1'b0; start64 = 1'b0; start32 = 1'b0;
    seedMem();
    tick();
    rst = 1'b1;
    q64.delete(); q32.delete(); tail64 = 0; tail32 = 0;
    chkEn = 1'b1;
    check("reset ready64", ready64, 1);
    check("reset adr64", adr64, 0);
    check("reset done64", done64, 0);
    check("reset ready32", ready32, 1);
    repeat (20) tick();

    // Full default run
    seedMem();
    launch64(1);
    tick();
    start64 = 1'b0;
    waitDrain(2000);
    check("done cycle 64", doneCyc64 - startCyc64, 757);
    check("lane 2 rotates 64", rc64[2], 62);
    check("lane 0 rotates 64", rc64[0], 0);
    checkMem64(25, 1);

    // 32-bit lanes
    seedMem();
    launch32();
    tick();
    start32 = 1'b0;
    waitDrain(2000);
    check("done cycle 32", doneCyc32 - startCyc32, 437);
    check("lane 2 rotates 32", rc32[2], 30);
    check("lane 20 rotates 32", rc32[20], 18);
    checkMem32();

    // Abort during lane 7 rotation
    seedMem();
    launch64(1);
    tick();
    start64 = 1'b0;
    n = 0;
    while (!(q64.size() > 0 && q64[0] == mk(0, 0, 0, 0, 1, 0, 7)) && n < 3000) begin
      tick();
      n++;
    end
    check("reached lane 7 rotate", n < 3000, 1);
    rst = 1'b0;
    tick();
    q64.delete(); q32.delete(); tail64 = 0; tail32 = 0;
    rst = 1'b1;
    check("ready after abort", ready64, 1);
    check("adr after abort", adr64, 0);
    repeat (3) tick();
    checkMem64(7, 1);
    seedMem();
    launch64(1);
    tick();
    start64 = 1'b0;
    waitDrain(2000);
    checkMem64(25, 1);

    // start toggling during a run
    seedMem();
    launch64(1);
    tick();
    while (q64.size() > 5) begin
      start64 = 1'($urandom_range(0, 1));
      tick();
    end
    start64 = 1'b0;
    waitDrain(100);
    checkMem64(25, 1);

    // start held high: back-to-back runs with one Idle cycle between
    seedMem();
    launch64(2);
    while (q64.size() > 700) tick();
    start64 = 1'b0;
    waitDrain(4000);
    checkMem64(25, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got %0d checks passed expected run to finish", passed);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rho_rotate_controller.md
Name: rho_rotate_controller

Overview:
- Sequences the Keccak rho step over the 25-lane state memory, which the column-parity stage has already updated.
- Each lane is read into the shared lane register, rotated left one bit per cycle by that lane's fixed rho offset, then written back in place.
- Instantiated beside the lane datapath (memory, lane register with 1-bit left-rotate, address mux). Drives only control strobes and the lane address.

Parameters:
- LANES, 25, number of lanes processed per run (lane index 0..LANES-1, index = x + 5*y).
- LANE_W, 64, lane width in bits; rotation amount = rho offset mod LANE_W.
- ADR_W, 5, width of lane address output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in Idle.
- ready  out  1  high in Idle.
- memRead  out  1  memory read strobe for lane adr.
- memWrite  out  1  memory write strobe for lane adr (lane register contents).
- adr  out  ADR_W  current lane index.
- regLd  out  1  load lane register from memory read data.
- regRotL  out  1  rotate lane register left by one bit this cycle.
- done  out  1  one-cycle pulse when all lanes are written.

Behaviour:
- Reset (rst=0 at a clock edge): state=Idle, laneCnt=0, rotCnt=0, all strobes 0, done=0, ready=1 in the following cycle.
  - Reset mid-run aborts immediately. Lanes already written stay written; no further strobes.
- Outputs are Moore-decoded from state. adr = laneCnt in every state. Every strobe not listed for a state is 0.
- Rho offset table, fixed internal combinational function of laneCnt, by index 0..24:
  - 0,1,62,28,27
  - 36,44,6,55,20
  - 3,10,43,25,39
  - 41,45,15,21,8
  - 18,2,61,56,14
  - Offsets are reduced mod LANE_W. Indices >= 25 (if LANES > 25) use offset 0.
- States and transitions:
  - Idle: ready=1. start=1 -> Init; else stay.
  - Init: laneCnt<=0. -> Read.
  - Read: memRead=1. -> Load.
  - Load: regLd=1; rotCnt <= offset(laneCnt) mod LANE_W. Reduced offset = 0 -> Write, else -> Rotate.
  - Rotate: regRotL=1; rotCnt <= rotCnt-1. rotCnt==1 -> Write, else stay. This gives exactly offset rotate cycles.
  - Write: memWrite=1. laneCnt==LANES-1 -> Done; else laneCnt<=laneCnt+1 and -> Read.
  - Done: done=1. -> Idle.
- Per-lane cost is 3 + offset cycles. With the defaults, the offset sum is 680 and the run takes 755 lane cycles.
  - Counting the edge that samples start as edge 0: Init in cycle 1, first Read in cycle 2, done high in cycle 757, ready high again in cycle 758.
- start is ignored outside Idle. If start is held high, a new run begins in the cycle after Idle is entered (Idle lasts one cycle).
- rotCnt is ceil(log2(LANE_W)) bits; laneCnt is ADR_W bits. Neither counter wraps during a legal run.
- memRead and memWrite are never high in the same cycle. regLd and regRotL are never high in the same cycle.

Test Plan:
- Reset then idle: hold rst=0 two cycles, release -> ready=1, all strobes/done=0, adr=0. start=0 for 20 cycles -> no strobes.
- Full run, defaults: pulse start -> 25 Read/Load/Write triples at adr 0..24 in order.
  - regRotL count per lane equals the table value (lane 2: 62, lane 0: 0).
  - done in cycle 757, single cycle; ready in cycle 758. Golden memory model matches Keccak rho on a random state.
- Zero-offset lane: lane 0 -> Load directly followed by Write; no regRotL cycles.
- LANE_W=32: lane 2 rotates 30 cycles, lane 20 (offset 18) rotates 18; total done cycle matches recomputed sum.
- Reset mid-run: assert rst=0 during Rotate of lane 7 -> next cycle Idle, ready=1. No memWrite for lane 7.
  - A new start restarts at adr 0.
- start during run / held high: toggle start throughout a run -> no effect until Done. start held high -> second run's Init follows exactly one Idle cycle after done.
